// File: rtl/jtcop_vram_arb.sv
// jtcop_vram_arb: round-robin SDRAM read arbiter for three BAC06 map readers, each with a one-word hit cache
module jtcop_vram_arb #(
    parameter int          AW        = 22,
    parameter logic [AW-1:0] B0_OFFSET = 22'h10_0000,
    parameter logic [AW-1:0] B1_OFFSET = 22'h10_2000,
    parameter logic [AW-1:0] B2_OFFSET = 22'h10_2800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          b0_cs,
    input  logic [12:0]   b0_addr,
    output logic [15:0]   b0_data,
    output logic          b0_ok,
    input  logic          b1_cs,
    input  logic [10:0]   b1_addr,
    output logic [15:0]   b1_data,
    output logic          b1_ok,
    input  logic          b2_cs,
    input  logic [10:0]   b2_addr,
    output logic [15:0]   b2_data,
    output logic          b2_ok,
    input  logic [2:0]    flush,
    output logic [AW-1:0] ba_addr,
    output logic          ba_rd,
    input  logic          ba_ack,
    input  logic          ba_rdy,
    input  logic [15:0]   data_read
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
    state_t        st;
    logic [12:0]   addr_l [3];
    logic [15:0]   data_l [3];
    logic [12:0]   cur [3];
    logic [AW-1:0] off [3];
    logic [2:0]    cs, hit, miss, valid, valid_n;
    logic [1:0]    rr, r1, r2, sel, gnt;
    logic [12:0]   req_addr;
    logic          kill, cap;
    assign cur = '{b0_addr, {2'b0, b1_addr}, {2'b0, b2_addr}};
    assign off = '{B0_OFFSET, B1_OFFSET, B2_OFFSET};
    assign cs  = {b2_cs, b1_cs, b0_cs};
    always_comb begin
        for (int n = 0; n < 3; n++) hit[n] = cs[n] & valid[n] & (addr_l[n] == cur[n]);
    end
    assign miss = cs & ~hit;
    assign {b2_ok, b1_ok, b0_ok} = hit;
    assign b0_data = data_l[0];
    assign b1_data = data_l[1];
    assign b2_data = data_l[2];
    assign r1  = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    assign r2  = rr == 2'd0 ? 2'd2 : rr - 2'd1;
    assign sel = miss[rr] ? rr : miss[r1] ? r1 : r2;
    assign cap = ba_rdy & ((st == WAIT_ACK & ba_ack) | st == WAIT_RDY);
    // a flush seen at any point of a fetch poisons its result
    always_comb begin
        for (int n = 0; n < 3; n++)
            valid_n[n] = (cap && gnt == 2'(n)) ? ~(kill | flush[n]) : valid[n] & ~flush[n];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ba_rd    <= 1'b0;
            ba_addr  <= '0;
            valid    <= '0;
            rr       <= '0;
            gnt      <= '0;
            req_addr <= '0;
            kill     <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                addr_l[n] <= '0;
                data_l[n] <= '0;
            end
        end else begin
            valid <= valid_n;
            kill  <= st == IDLE ? |miss & flush[sel] : kill | flush[gnt];
            if (cap) begin
                data_l[gnt] <= data_read;
                addr_l[gnt] <= req_addr;
                rr          <= gnt == 2'd2 ? 2'd0 : gnt + 2'd1;
            end
            case (st)
                IDLE: if (|miss) begin
                    gnt      <= sel;
                    req_addr <= cur[sel];
                    ba_addr  <= off[sel] + AW'(cur[sel]);
                    ba_rd    <= 1'b1;
                    st       <= WAIT_ACK;
                end
                WAIT_ACK: if (ba_ack) begin
                    ba_rd <= 1'b0;
                    st    <= ba_rdy ? IDLE : WAIT_RDY;
                end
                WAIT_RDY: if (ba_rdy) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcop_vram_arb.sv
// tb_jtcop_vram_arb: directed self-checking bench for jtcop_vram_arb
module tb_jtcop_vram_arb;
    logic        clk = 0, rst = 0;
    logic        b0_cs = 0, b1_cs = 0, b2_cs = 0;
    logic [12:0] b0_addr = 0;
    logic [10:0] b1_addr = 0, b2_addr = 0;
    logic [15:0] b0_data, b1_data, b2_data, data_read = 0;
    logic        b0_ok, b1_ok, b2_ok, ba_rd;
    logic [2:0]  flush = 0;
    logic [21:0] ba_addr;
    logic        ba_ack = 0, ba_rdy = 0;
    int compared = 0, mismatched = 0;

    jtcop_vram_arb dut (
        .clk(clk), .rst(rst),
        .b0_cs(b0_cs), .b0_addr(b0_addr), .b0_data(b0_data), .b0_ok(b0_ok),
        .b1_cs(b1_cs), .b1_addr(b1_addr), .b1_data(b1_data), .b1_ok(b1_ok),
        .b2_cs(b2_cs), .b2_addr(b2_addr), .b2_data(b2_data), .b2_ok(b2_ok),
        .flush(flush), .ba_addr(ba_addr), .ba_rd(ba_rd),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // SDRAM responder: ack ack_c cycles after ba_rd, rdy rdy_c cycles after ba_rd (equal = same cycle)
    task automatic serve(input int ack_c, input int rdy_c, input logic [15:0] d,
                         input logic [21:0] exp_addr, input logic [2:0] fl, input string nm);
        int n = 0;
        while (!ba_rd && n < 20) begin
            tick;
            n++;
        end
        compared++;
        if (ba_rd !== 1'b1 || ba_addr !== exp_addr) begin
            mismatched++;
            $display("FAIL %s request: ba_rd=%b ba_addr=%h, expected 1 %h", nm, ba_rd, ba_addr, exp_addr);
        end
        repeat (ack_c - 1) tick;
        ba_ack = 1;
        if (rdy_c == ack_c) begin
            ba_rdy = 1;
            data_read = d;
            flush = fl;
        end
        tick;
        ba_ack = 0;
        compared++;
        if (ba_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL %s rd_drop: ba_rd=%b, expected 0", nm, ba_rd);
        end
        if (rdy_c > ack_c) begin
            repeat (rdy_c - ack_c - 1) tick;
            ba_rdy = 1;
            data_read = d;
            flush = fl;
            tick;
        end
        ba_rdy = 0;
        flush = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        b0_cs = 1; b1_cs = 1; b2_cs = 1;
        b0_addr = 0; b1_addr = 0; b2_addr = 0;
        #1;
        compared++;
        if ({ba_rd, ba_addr, b0_ok, b1_ok, b2_ok} !== 26'd0 || {b0_data, b1_data, b2_data} !== 48'd0) begin
            mismatched++;
            $display("FAIL reset: rd=%b addr=%h ok=%b%b%b data=%h %h %h, expected all 0",
                     ba_rd, ba_addr, b0_ok, b1_ok, b2_ok, b0_data, b1_data, b2_data);
        end
        b0_cs = 0; b1_cs = 0; b2_cs = 0;
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_single_miss;
        b0_cs = 1;
        b0_addr = 13'h0123;
        #1;
        compared++;
        if (b0_ok !== 1'b0 || ba_rd !== 1'b0) begin
            mismatched++;
            $display("FAIL miss_idle: ok=%b rd=%b, expected 0 0", b0_ok, ba_rd);
        end
        tick;
        compared++;
        if (ba_rd !== 1'b1) begin
            mismatched++;
            $display("FAIL latency: ba_rd=%b one cycle after miss, expected 1", ba_rd);
        end
        serve(2, 5, 16'hBEEF, 22'h10_0123, 3'b000, "b0_fetch");
        compared++;
        if (b0_ok !== 1'b1 || b0_data !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL b0_capture: ok=%b data=%h, expected 1 beef", b0_ok, b0_data);
        end
    endtask

    task automatic test_hit;
        repeat (3) begin
            tick;
            compared++;
            if (b0_ok !== 1'b1 || ba_rd !== 1'b0 || b0_data !== 16'hBEEF) begin
                mismatched++;
                $display("FAIL hit: ok=%b rd=%b data=%h, expected 1 0 beef", b0_ok, ba_rd, b0_data);
            end
        end
    endtask

    task automatic test_round_robin;
        test_reset;
        b0_cs = 1; b0_addr = 13'h0200;
        b1_cs = 1; b1_addr = 11'h011;
        b2_cs = 1; b2_addr = 11'h022;
        serve(2, 4, 16'h1111, 22'h10_0200, 3'b000, "rr0");
        compared++;
        if (b0_ok !== 1'b1 || b1_ok !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_hit_during: b0_ok=%b b1_ok=%b, expected 1 0", b0_ok, b1_ok);
        end
        serve(1, 3, 16'h2222, 22'h10_2011, 3'b000, "rr1");
        serve(3, 3, 16'h3333, 22'h10_2822, 3'b000, "rr2");
        compared++;
        if ({b0_ok, b1_ok, b2_ok} !== 3'b111 || {b0_data, b1_data, b2_data} !== 48'h1111_2222_3333) begin
            mismatched++;
            $display("FAIL rr_first: ok=%b%b%b data=%h %h %h, expected 111 1111 2222 3333",
                     b0_ok, b1_ok, b2_ok, b0_data, b1_data, b2_data);
        end
        b0_addr = 13'h0201; b1_addr = 11'h012; b2_addr = 11'h023;
        serve(1, 1, 16'h4444, 22'h10_0201, 3'b000, "rr0b");
        serve(2, 2, 16'h5555, 22'h10_2012, 3'b000, "rr1b");
        serve(1, 2, 16'h6666, 22'h10_2823, 3'b000, "rr2b");
        compared++;
        if ({b0_ok, b1_ok, b2_ok} !== 3'b111 || {b0_data, b1_data, b2_data} !== 48'h4444_5555_6666) begin
            mismatched++;
            $display("FAIL rr_second: ok=%b%b%b data=%h %h %h, expected 111 4444 5555 6666",
                     b0_ok, b1_ok, b2_ok, b0_data, b1_data, b2_data);
        end
    endtask

    task automatic test_flush;
        b0_cs = 0; b2_cs = 0;
        b1_addr = 11'h030;
        serve(2, 4, 16'hDEAD, 22'h10_2030, 3'b010, "flush_fetch");
        compared++;
        if (b1_ok !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_win: b1_ok=%b, expected 0", b1_ok);
        end
        serve(1, 2, 16'hCAFE, 22'h10_2030, 3'b000, "flush_refetch");
        compared++;
        if (b1_ok !== 1'b1 || b1_data !== 16'hCAFE) begin
            mismatched++;
            $display("FAIL flush_refill: ok=%b data=%h, expected 1 cafe", b1_ok, b1_data);
        end
        flush = 3'b010;
        tick;
        flush = 0;
        compared++;
        if (b1_ok !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle: b1_ok=%b, expected 0", b1_ok);
        end
        b1_cs = 0;
        tick;
        tick;
    endtask

    task automatic test_addr_change;
        b2_cs = 1;
        b2_addr = 11'h010;
        tick;
        b2_addr = 11'h011;
        serve(2, 4, 16'hA010, 22'h10_2810, 3'b000, "chg_first");
        compared++;
        if (b2_ok !== 1'b0) begin
            mismatched++;
            $display("FAIL chg_ok: b2_ok=%b, expected 0", b2_ok);
        end
        b2_addr = 11'h010;
        #1;
        compared++;
        if (b2_ok !== 1'b1 || b2_data !== 16'hA010) begin
            mismatched++;
            $display("FAIL chg_cached: ok=%b data=%h, expected 1 a010", b2_ok, b2_data);
        end
        b2_addr = 11'h011;
        serve(1, 3, 16'hA011, 22'h10_2811, 3'b000, "chg_second");
        compared++;
        if (b2_ok !== 1'b1 || b2_data !== 16'hA011) begin
            mismatched++;
            $display("FAIL chg_refill: ok=%b data=%h, expected 1 a011", b2_ok, b2_data);
        end
        b2_cs = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        b0_cs = 1;
        b0_addr = 13'h0300;
        tick;
        compared++;
        if (ba_rd !== 1'b1 || ba_addr !== 22'h10_0300) begin
            mismatched++;
            $display("FAIL mid_req: rd=%b addr=%h, expected 1 100300", ba_rd, ba_addr);
        end
        ba_ack = 1;
        tick;
        ba_ack = 0;
        b0_cs = 0;
        rst = 1;
        #1;
        compared++;
        if (ba_rd !== 1'b0 || ba_addr !== 22'd0) begin
            mismatched++;
            $display("FAIL mid_async: rd=%b addr=%h, expected 0 0", ba_rd, ba_addr);
        end
        tick;
        rst = 0;
        ba_ack = 1; ba_rdy = 1; data_read = 16'h7777;
        tick;
        ba_ack = 0; ba_rdy = 0;
        tick;
        b0_cs = 1; b1_cs = 1; b2_cs = 1;
        b0_addr = 13'h0300; b1_addr = 11'h030; b2_addr = 11'h011;
        #1;
        compared++;
        if (ba_rd !== 1'b0 || {b0_ok, b1_ok, b2_ok} !== 3'b000 || b0_data !== 16'h0000) begin
            mismatched++;
            $display("FAIL mid_late: rd=%b ok=%b%b%b data=%h, expected 0 000 0000",
                     ba_rd, b0_ok, b1_ok, b2_ok, b0_data);
        end
    endtask

    initial begin
        test_reset;
        test_single_miss;
        test_hit;
        test_round_robin;
        test_flush;
        test_addr_change;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
